// File: rtl/cache_nway_wb_if.sv
// CPU-side and memory-side bus bundle for the N-way write-back cache.
// The cache is the slave; the CPU/memory environment is the master.
interface cache_nway_wb_if;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   modport master (
      output mem_address, mem_read, mem_write,
      output mem_byte_enable, mem_wdata,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_read, pmem_write,
      input  pmem_wdata,
      output pmem_rdata, pmem_resp,
      input  hit_count, miss_count
   );

   modport slave (
      input  mem_address, mem_read, mem_write,
      input  mem_byte_enable, mem_wdata,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_read, pmem_write,
      output pmem_wdata,
      input  pmem_rdata, pmem_resp,
      output hit_count, miss_count
   );
endinterface

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back/write-allocate L1 cache.
// Tree pseudo-LRU replacement, saturating hit/miss counters.
module cache_nway_wb #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int num_ways = 4,
   parameter int s_tag    = 32 - s_offset - s_index
) (
   input logic            clk,
   input logic            rst_n,
   cache_nway_wb_if.slave bus
);
   localparam int SETS = 2 ** s_index;
   localparam int LW   = 8 * (2 ** s_offset);
   localparam int LVL  = $clog2(num_ways);
   localparam int NWB  = (num_ways > 1) ? LVL : 1;
   localparam int PW   = (num_ways > 1) ? num_ways - 1 : 1;
   localparam int WSEL = s_offset - 2;

   typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_e;
   state_e state_q, state_d;

   logic [s_tag-1:0]    tag_q   [SETS][num_ways];
   logic [LW-1:0]       data_q  [SETS][num_ways];
   logic [num_ways-1:0] valid_q [SETS];
   logic [num_ways-1:0] dirty_q [SETS];
   logic [PW-1:0]       plru_q  [SETS];
   logic [NWB-1:0]      vict_q, vict_d;
   logic [31:0]         hit_q, miss_q;
   logic                refill_q;

   logic [s_tag-1:0]   tag_w;
   logic [s_index-1:0] idx_w;
   logic [WSEL-1:0]    wsel_w;
   logic               req_w, wr_w;
   logic               hit_w, found_w;
   logic [NWB-1:0]     hway_w;
   logic [PW-1:0]      plru_nx;
   logic [LW-1:0]      line_w, merged_w;
   logic [31:0]        word_w, wnew_w;
   logic               do_hit, do_miss;
   int                 vnode, unode, udir;
   logic               unused_ok;

   assign tag_w     = bus.mem_address[31 -: s_tag];
   assign idx_w     = bus.mem_address[s_offset +: s_index];
   assign wsel_w    = bus.mem_address[2 +: WSEL];
   assign req_w     = bus.mem_read | bus.mem_write;
   assign wr_w      = bus.mem_write;
   assign unused_ok = ^bus.mem_address[1:0];

   always_comb begin
      hit_w  = 1'b0;
      hway_w = '0;
      for (int i = 0; i < num_ways; i++)
         if (valid_q[idx_w][i] && tag_q[idx_w][i] == tag_w) begin
            hit_w  = 1'b1;
            hway_w = NWB'(i);
         end
   end

   // Victim: lowest invalid way first, otherwise walk the PLRU tree.
   always_comb begin
      vict_d  = '0;
      found_w = 1'b0;
      vnode   = 0;
      for (int i = 0; i < num_ways; i++)
         if (!found_w && !valid_q[idx_w][i]) begin
            found_w = 1'b1;
            vict_d  = NWB'(i);
         end
      if (!found_w) begin
         for (int l = 0; l < LVL; l++)
            vnode = 2 * vnode + 1 +
                    int'((plru_q[idx_w] >> vnode) & PW'(1));
         vict_d = NWB'(vnode - (num_ways - 1));
      end
   end

   // Each node on the path to the hit way is pointed away from it.
   always_comb begin
      plru_nx = plru_q[idx_w];
      unode   = 0;
      udir    = 0;
      for (int l = 0; l < LVL; l++) begin
         udir    = (int'(hway_w) >> (LVL - 1 - l)) & 1;
         plru_nx = plru_nx & ~(PW'(1) << unode);
         if (udir == 0)
            plru_nx = plru_nx | (PW'(1) << unode);
         unode = 2 * unode + 1 + udir;
      end
   end

   always_comb begin
      line_w = data_q[idx_w][hway_w];
      word_w = line_w[{wsel_w, 5'd0} +: 32];
      wnew_w = word_w;
      for (int b = 0; b < 4; b++)
         if (bus.mem_byte_enable[b])
            wnew_w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      merged_w = line_w;
      merged_w[{wsel_w, 5'd0} +: 32] = wnew_w;
   end

   always_comb begin
      state_d          = state_q;
      bus.mem_resp     = 1'b0;
      bus.mem_rdata    = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      do_hit           = 1'b0;
      do_miss          = 1'b0;
      unique case (state_q)
         IDLE: if (req_w) state_d = CHECK;
         CHECK: begin
            if (hit_w) begin
               bus.mem_resp  = 1'b1;
               bus.mem_rdata = word_w;
               do_hit        = 1'b1;
               state_d       = IDLE;
            end else begin
               do_miss = 1'b1;
               state_d = dirty_q[idx_w][vict_d] ? WB : FILL;
            end
         end
         WB: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[idx_w][vict_q], idx_w,
                                {s_offset{1'b0}}};
            bus.pmem_wdata   = data_q[idx_w][vict_q];
            if (bus.pmem_resp) state_d = FILL;
         end
         FILL: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {tag_w, idx_w, {s_offset{1'b0}}};
            if (bus.pmem_resp) state_d = CHECK;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.hit_count  = hit_q;
   assign bus.miss_count = miss_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         vict_q   <= '0;
         hit_q    <= '0;
         miss_q   <= '0;
         refill_q <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         if (do_hit) begin
            plru_q[idx_w] <= plru_nx;
            refill_q      <= 1'b0;
            if (hit_q != '1) hit_q <= hit_q + 32'd1;
            if (wr_w) dirty_q[idx_w][hway_w] <= 1'b1;
         end
         // The recheck after a fill never counts as a second miss.
         if (do_miss) begin
            vict_q <= vict_d;
            if (!refill_q && miss_q != '1)
               miss_q <= miss_q + 32'd1;
         end
         if (state_q == WB && bus.pmem_resp)
            dirty_q[idx_w][vict_q] <= 1'b0;
         if (state_q == FILL && bus.pmem_resp) begin
            valid_q[idx_w][vict_q] <= 1'b1;
            dirty_q[idx_w][vict_q] <= 1'b0;
            refill_q               <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_hit && wr_w)
         data_q[idx_w][hway_w] <= merged_w;
      if (state_q == FILL && bus.pmem_resp) begin
         data_q[idx_w][vict_q] <= bus.pmem_rdata;
         tag_q[idx_w][vict_q]  <= tag_w;
      end
   end
endmodule

// File: tb/tb_cache_nway_wb.sv
// Scoreboard bench for cache_nway_wb: flat memory reference for data,
// explicit 4-way PLRU residency model for hit/miss counters.
module tb_cache_nway_wb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   cache_nway_wb_if bus();

   cache_nway_wb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;
   typedef struct {
      bit           wr;
      logic [31:0]  a;
      logic [255:0] d;
   } ev_t;

   exp_t sbq[$];
   ev_t  evq[$];
   logic [255:0] pm   [bit [31:0]];
   logic [31:0]  refm [bit [31:0]];

   int  n_chk = 0;
   int  n_pass = 0;
   int  overlap = 0;
   bit  stall = 1'b0;

   logic [23:0] mt [8][4];
   bit          mv [8][4];
   bit          pr [8];
   bit          pl [8];
   bit          prr[8];
   logic [31:0] m_hit = 0;
   logic [31:0] m_miss = 0;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   function automatic logic [255:0] get_line(input logic [31:0] la);
      logic [255:0] l;
      if (pm.exists(la)) return pm[la];
      for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word(la + 32'(4*i));
      return l;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      if (refm.exists(a)) return refm[a];
      return init_word(a);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 4; w++) mv[s][w] = 1'b0;
         pr[s] = 0; pl[s] = 0; prr[s] = 0;
      end
      m_hit = 0;
      m_miss = 0;
   endtask

   // Residency model: a miss allocates, then the post-fill recheck hits.
   task automatic model_access(input logic [31:0] a);
      int s, w;
      logic [23:0] t;
      s = int'(a[7:5]);
      t = a[31:8];
      w = -1;
      for (int i = 0; i < 4; i++) if (mv[s][i] && mt[s][i] == t) w = i;
      if (w < 0) begin
         if (m_miss != 32'hFFFF_FFFF) m_miss++;
         for (int i = 0; i < 4; i++) if (w < 0 && !mv[s][i]) w = i;
         if (w < 0) w = (pr[s] == 0) ? (pl[s] ? 1 : 0) : (prr[s] ? 3 : 2);
         mv[s][w] = 1'b1;
         mt[s][w] = t;
      end
      if (m_hit != 32'hFFFF_FFFF) m_hit++;
      pr[s] = (w < 2);
      if (w < 2) pl[s] = (w == 0);
      else prr[s] = (w == 2);
   endtask

   task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd,
                         output int lat);
      exp_t e;
      logic [31:0] w;
      e.a = a;
      e.rd = !wr;
      e.d = '0;
      if (wr) begin
         w = ref_word(a);
         for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
         refm[a] = w;
      end else e.d = ref_word(a);
      model_access(a);
      sbq.push_back(e);
      bus.mem_address = a;
      bus.mem_read = rd;
      bus.mem_write = wr;
      bus.mem_byte_enable = be;
      bus.mem_wdata = wd;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.mem_resp !== 1'b1 && lat < 300);
      if (bus.mem_resp !== 1'b1) begin
         n_chk++;
         $display("FAIL timeout addr %h: got no mem_resp, required one", a);
      end
      @(negedge clk);
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, " hit_count"}, bus.hit_count, m_hit);
      chk({nm, " miss_count"}, bus.miss_count, m_miss);
   endtask

   // Monitor: pops the scoreboard whenever the cache completes a request.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.mem_resp === 1'b1) begin
            if (sbq.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected mem_resp: got 1 required 0");
            end else begin
               e = sbq.pop_front();
               if (e.rd) chk($sformatf("rdata@%h", e.a), bus.mem_rdata, e.d);
            end
         end
      end
   end

   // Physical memory with random 1..4 cycle response latency.
   initial begin
      int cnt, lat;
      logic [31:0] la;
      cnt = 0;
      lat = 2;
      bus.pmem_resp = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1) overlap++;
         if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            cnt = 0;
         end else if ((bus.pmem_read || bus.pmem_write) && !stall) begin
            cnt++;
            if (cnt >= lat) begin
               la = bus.pmem_address;
               if (bus.pmem_write) begin
                  pm[la] = bus.pmem_wdata;
                  evq.push_back('{1'b1, la, bus.pmem_wdata});
               end else begin
                  bus.pmem_rdata = get_line(la);
                  evq.push_back('{1'b0, la, bus.pmem_rdata});
               end
               bus.pmem_resp = 1'b1;
               cnt = 0;
               lat = $urandom_range(1, 4);
            end
         end else cnt = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, op, k;
      logic [31:0] a;
      logic [255:0] l;
      bus.mem_address = '0;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_byte_enable = '0;
      bus.mem_wdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset mem_resp", bus.mem_resp, 0);
      chk("reset mem_rdata", bus.mem_rdata, 0);
      chk("reset pmem_read", bus.pmem_read, 0);
      chk("reset pmem_write", bus.pmem_write, 0);
      chk("reset pmem_address", bus.pmem_address, 0);
      chk("reset hit_count", bus.hit_count, 0);
      chk("reset miss_count", bus.miss_count, 0);
      rst_n = 1'b1;
      @(negedge clk);

      l = get_line(32'h1040);
      l[64 +: 32] = 32'hDEAD_BEEF;
      pm[32'h1040] = l;
      refm[32'h1048] = 32'hDEAD_BEEF;
      evq.delete();
      do_req(1, 0, 32'h1048, 4'h0, 32'h0, lat);
      chk("cold fill count", evq.size(), 1);
      if (evq.size() > 0) chk("cold fill addr", evq[0].a, 32'h1040);
      chk("cold hit_count", bus.hit_count, 1);
      chk("cold miss_count", bus.miss_count, 1);

      evq.delete();
      do_req(0, 1, 32'h1048, 4'b0011, 32'h1234_5678, lat);
      chk("write hit latency", lat, 1);
      do_req(1, 0, 32'h1048, 4'h0, 32'h0, lat);
      chk("read hit latency", lat, 1);
      chk("hit pmem traffic", evq.size(), 0);
      chk("after hits hit_count", bus.hit_count, 3);

      do_req(1, 0, 32'h1140, 4'h0, 32'h0, lat);
      do_req(1, 0, 32'h1240, 4'h0, 32'h0, lat);
      do_req(1, 0, 32'h1340, 4'h0, 32'h0, lat);
      evq.delete();
      do_req(1, 0, 32'h1440, 4'h0, 32'h0, lat);
      chk("evict event count", evq.size(), 2);
      if (evq.size() == 2) begin
         chk("wb is write", evq[0].wr, 1);
         chk("wb addr", evq[0].a, 32'h1040);
         chk("wb word2", evq[0].d[64 +: 32], 32'hDEAD_5678);
         chk("refill is read", evq[1].wr, 0);
         chk("refill addr", evq[1].a, 32'h1440);
      end
      do_req(1, 0, 32'h1040, 4'h0, 32'h0, lat);
      do_req(1, 0, 32'h1140, 4'h0, 32'h0, lat);
      chk("way1 survives latency", lat, 1);
      chk("plru miss_count", bus.miss_count, 6);
      chk("plru hit_count", bus.hit_count, 9);
      chk_cnt("plru model");

      stall = 1'b1;
      bus.mem_address = 32'h2000;
      bus.mem_read = 1'b1;
      k = 0;
      while (bus.pmem_read !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("abort fill started", bus.pmem_read, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort pmem_read", bus.pmem_read, 0);
      chk("abort pmem_write", bus.pmem_write, 0);
      chk("abort mem_resp", bus.mem_resp, 0);
      chk("abort hit_count", bus.hit_count, 0);
      chk("abort miss_count", bus.miss_count, 0);
      bus.mem_read = 1'b0;
      stall = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_req(1, 0, 32'h2000, 4'h0, 32'h0, lat);
      chk("post-reset miss_count", bus.miss_count, 1);
      chk("post-reset hit_count", bus.hit_count, 1);

      for (int n = 0; n < 400; n++) begin
         a = (32'($urandom_range(16, 21)) << 8) |
             (32'($urandom_range(0, 7)) << 5) |
             (32'($urandom_range(0, 7)) << 2);
         op = $urandom_range(0, 2);
         do_req(op != 1, op != 0, a, 4'($urandom_range(0, 15)),
                $urandom, lat);
         if (n % 50 == 49) chk_cnt($sformatf("random %0d", n));
      end

      force dut.hit_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.hit_q;
      m_hit = 32'hFFFF_FFFE;
      @(negedge clk);
      do_req(1, 0, 32'h1000, 4'h0, 32'h0, lat);
      chk("sat hit_count 1", bus.hit_count, m_hit);
      do_req(1, 0, 32'h1000, 4'h0, 32'h0, lat);
      chk("sat hit_count 2", bus.hit_count, 32'hFFFF_FFFF);

      chk("pmem read/write overlap", overlap, 0);
      chk("scoreboard drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
